flit_serdes_lane: RTL and testbench

- Bidirectional parametrised flit serializer/deserializer for the inter-node serial links of the line NoC.
- Generalises the current 1-bit sflit/sready link to LANE_W-bit lanes.
- Adds even-parity protection, framing-error detection and an RX elastic buffer with credit-style ready.
- Instantiated once per node between the router parallel port and its serial neighbour link.

---
 rtl/noc_serdes_pkg.sv | 18 +
 rtl/flit_fifo.sv | 66 ++++++
 rtl/flit_serdes_lane.sv | 167 ++++++++++++++++
 tb/tb_flit_serdes_lane.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_serdes_pkg.sv
// Shared definitions for the serial flit link: frame geometry, parity and error codes.
package noc_serdes_pkg;

  localparam int FLIT_W_DEF = 34;
  localparam int PAR_MAX_W  = 256;

  typedef enum logic [1:0] {ERR_NONE, ERR_PARITY, ERR_FRAME, ERR_OVF} err_code_e;

  // ceil((flit_w + 1) / lane_w): one parity bit rides with every flit
  function automatic int beats_per_frame(input int flit_w, input int lane_w);
    return (flit_w + lane_w) / lane_w;
  endfunction

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous first-word-fall-through flit FIFO; head visible the cycle after push.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module flit_fifo #(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 34,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FLIT_W-1:0] push_flit,
  input  logic              pop,
  output logic [FLIT_W-1:0] head_flit,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [FLIT_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_flit = mem_q[rd_ptr_q];
  assign do_pop    = pop && (count_q != '0);
  assign do_push   = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_flit;
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/flit_serdes_lane.sv
// Parity-framed flit serializer/deserializer for one NoC serial link; loopback latency NB+1 cycles.
// TX checks s_out_ready once per flit; RX grants credit through a registered s_in_ready.
module flit_serdes_lane
  import noc_serdes_pkg::*;
#(
  parameter int FLIT_W    = FLIT_W_DEF,
  parameter int LANE_W    = 1,
  parameter int DEPTH     = 4,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_W-1:0]    p_in_flit,
  input  logic                 p_in_valid,
  output logic                 p_in_ready,
  output logic [LANE_W-1:0]    s_out_data,
  output logic                 s_out_frame,
  input  logic                 s_out_ready,
  input  logic [LANE_W-1:0]    s_in_data,
  input  logic                 s_in_frame,
  output logic                 s_in_ready,
  output logic [FLIT_W-1:0]    p_out_flit,
  output logic                 p_out_valid,
  input  logic                 p_out_ready,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int NB      = beats_per_frame(FLIT_W, LANE_W);
  localparam int FRAME_W = NB * LANE_W;
  localparam int BEAT_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB - 1);

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;

  tx_state_e              tx_state_q, tx_state_d;
  logic [BEAT_W-1:0]      tx_beat_q, tx_beat_d;
  logic [FRAME_W-1:0]     tx_sh_q, tx_sh_d;
  logic [LANE_W-1:0]      s_out_data_q, s_out_data_d;
  logic                   s_out_frame_q, s_out_frame_d;
  logic [BEAT_W-1:0]      rx_beat_q, rx_beat_d;
  logic [FRAME_W-1:0]     rx_sh_q, rx_sh_d;
  logic                   s_in_ready_q, s_in_ready_d;
  logic                   err_pulse_q, err_pulse_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                   live_q;

  logic                   out_en, tx_hs;
  logic [FRAME_W-1:0]     tx_frame, rx_asm;
  logic [FLIT_W-1:0]      rx_flit, fifo_head;
  logic                   rx_good, fifo_full, fifo_pop, fifo_push_eff;
  logic [CNT_W-1:0]       fifo_count;
  err_code_e              rx_err;
  int                     cnt_next, inflight_next;

  // live_q keeps every handshake output low for the first cycle after reset
  assign out_en      = live_q && !rst;
  assign p_in_ready  = out_en && s_out_ready && (tx_state_q == TX_IDLE || tx_beat_q == LAST_BEAT);
  assign tx_hs       = p_in_valid && p_in_ready;
  assign tx_frame    = FRAME_W'({even_parity(PAR_MAX_W'(p_in_flit)), p_in_flit});
  assign s_out_data  = s_out_data_q;
  assign s_out_frame = s_out_frame_q;
  assign s_in_ready  = s_in_ready_q;
  assign err_pulse   = err_pulse_q;
  assign err_cnt     = err_cnt_q;
  assign p_out_valid = out_en && (fifo_count != '0);
  assign p_out_flit  = p_out_valid ? fifo_head : '0;
  assign fifo_pop    = p_out_valid && p_out_ready;
  assign fifo_push_eff = rx_good && (!fifo_full || fifo_pop);

  always_comb begin
    tx_state_d    = tx_state_q;
    tx_beat_d     = tx_beat_q;
    tx_sh_d       = tx_sh_q;
    s_out_data_d  = '0;
    s_out_frame_d = 1'b0;
    if (tx_hs) begin
      tx_state_d    = TX_SHIFT;
      tx_beat_d     = '0;
      s_out_data_d  = tx_frame[LANE_W-1:0];
      s_out_frame_d = 1'b1;
      tx_sh_d       = tx_frame >> LANE_W;
    end else if (tx_state_q == TX_SHIFT && tx_beat_q != LAST_BEAT) begin
      tx_beat_d     = tx_beat_q + BEAT_W'(1);
      s_out_data_d  = tx_sh_q[LANE_W-1:0];
      s_out_frame_d = 1'b1;
      tx_sh_d       = tx_sh_q >> LANE_W;
    end else begin
      tx_state_d = TX_IDLE;
      tx_beat_d  = '0;
    end
  end

  always_comb begin
    rx_asm = rx_sh_q;
    rx_asm[int'(rx_beat_q) * LANE_W +: LANE_W] = s_in_data;
    rx_flit   = rx_asm[FLIT_W-1:0];
    rx_beat_d = rx_beat_q;
    rx_sh_d   = rx_sh_q;
    rx_good   = 1'b0;
    rx_err    = ERR_NONE;
    if (s_in_frame) begin
      if (rx_beat_q == LAST_BEAT) begin
        rx_beat_d = '0;
        if (rx_asm[FLIT_W] == even_parity(PAR_MAX_W'(rx_flit))) rx_good = 1'b1;
        else rx_err = ERR_PARITY;
      end else begin
        rx_beat_d = rx_beat_q + BEAT_W'(1);
        rx_sh_d   = rx_asm;
      end
    end else if (rx_beat_q != '0) begin
      rx_beat_d = '0;
      rx_err    = ERR_FRAME;
    end
    if (rx_good && fifo_full && !fifo_pop) rx_err = ERR_OVF;
  end

  // Credit looks one cycle ahead: space left after this cycle's push/pop and any frame still arriving
  always_comb begin
    cnt_next      = int'(fifo_count) + int'(fifo_push_eff) - int'(fifo_pop);
    inflight_next = (rx_beat_d != '0) ? 1 : 0;
    s_in_ready_d  = (DEPTH - cnt_next - inflight_next) >= 2;
    err_pulse_d   = (rx_err != ERR_NONE);
    err_cnt_d     = (err_pulse_d && err_cnt_q != '1) ? err_cnt_q + ERR_CNT_W'(1) : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q    <= TX_IDLE;
      tx_beat_q     <= '0;
      tx_sh_q       <= '0;
      s_out_data_q  <= '0;
      s_out_frame_q <= 1'b0;
      rx_beat_q     <= '0;
      rx_sh_q       <= '0;
      s_in_ready_q  <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_cnt_q     <= '0;
      live_q        <= 1'b0;
    end else begin
      tx_state_q    <= tx_state_d;
      tx_beat_q     <= tx_beat_d;
      tx_sh_q       <= tx_sh_d;
      s_out_data_q  <= s_out_data_d;
      s_out_frame_q <= s_out_frame_d;
      rx_beat_q     <= rx_beat_d;
      rx_sh_q       <= rx_sh_d;
      s_in_ready_q  <= s_in_ready_d;
      err_pulse_q   <= err_pulse_d;
      err_cnt_q     <= err_cnt_d;
      live_q        <= 1'b1;
    end
  end

  flit_fifo #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_good),
    .push_flit (rx_flit),
    .pop       (fifo_pop),
    .head_flit (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_flit_serdes_lane.sv
// Loopback bench: an 8-bit-lane instance under scoreboard checking plus a 1-bit-lane instance for latency.
module tb_flit_serdes_lane;

  localparam int FLIT_W = 34;
  localparam int DEPTH  = 4;
  localparam int ERR_W  = 16;
  localparam int LANE_W = 8;
  localparam int NB     = (FLIT_W + 1 + LANE_W - 1) / LANE_W;
  localparam int NB1    = FLIT_W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [FLIT_W-1:0] p_in_flit;
  logic              p_in_valid, p_in_ready;
  logic [LANE_W-1:0] s_out_data, s_in_data, inj_mask;
  logic              s_out_frame, s_in_frame, s_in_ready, drop_frame;
  logic [FLIT_W-1:0] p_out_flit;
  logic              p_out_valid, p_out_ready;
  logic              err_pulse;
  logic [ERR_W-1:0]  err_cnt;
  logic              rdy_manual, rand_rdy_mode, rnd_rdy;

  assign s_in_data   = s_out_data ^ inj_mask;
  assign s_in_frame  = s_out_frame & ~drop_frame;
  assign p_out_ready = rand_rdy_mode ? rnd_rdy : rdy_manual;

  flit_serdes_lane #(.FLIT_W(FLIT_W), .LANE_W(LANE_W), .DEPTH(DEPTH), .ERR_CNT_W(ERR_W)) u_dut (
    .clk(clk), .rst(rst),
    .p_in_flit(p_in_flit), .p_in_valid(p_in_valid), .p_in_ready(p_in_ready),
    .s_out_data(s_out_data), .s_out_frame(s_out_frame), .s_out_ready(s_in_ready),
    .s_in_data(s_in_data), .s_in_frame(s_in_frame), .s_in_ready(s_in_ready),
    .p_out_flit(p_out_flit), .p_out_valid(p_out_valid), .p_out_ready(p_out_ready),
    .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  logic [FLIT_W-1:0] p1_in_flit, p1_out_flit;
  logic              p1_in_valid, p1_in_ready, p1_out_ready, p1_out_valid;
  logic [0:0]        s1_data;
  logic              s1_frame, s1_rdy, err1_pulse;
  logic [ERR_W-1:0]  err1_cnt;

  flit_serdes_lane #(.FLIT_W(FLIT_W), .LANE_W(1), .DEPTH(DEPTH), .ERR_CNT_W(ERR_W)) u_dut1 (
    .clk(clk), .rst(rst),
    .p_in_flit(p1_in_flit), .p_in_valid(p1_in_valid), .p_in_ready(p1_in_ready),
    .s_out_data(s1_data), .s_out_frame(s1_frame), .s_out_ready(s1_rdy),
    .s_in_data(s1_data), .s_in_frame(s1_frame), .s_in_ready(s1_rdy),
    .p_out_flit(p1_out_flit), .p_out_valid(p1_out_valid), .p_out_ready(p1_out_ready),
    .err_pulse(err1_pulse), .err_cnt(err1_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [FLIT_W-1:0] exp_q[$];
  logic [FLIT_W-1:0] exp_flit;
  int pulses_seen = 0;
  int run_cur = 0;
  int last_run = 0;
  int exp_err = 0;
  int exp_pulses = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: pops an expected flit whenever the DUT hands one over
  always @(negedge clk) begin
    if (!rst) begin
      if (p_out_valid && p_out_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_flit", 64'(p_out_flit), 64'h0);
        end else begin
          exp_flit = exp_q.pop_front();
          chk(p_out_flit == exp_flit, "flit_order", 64'(p_out_flit), 64'(exp_flit));
        end
      end
      if (err_pulse) pulses_seen++;
    end
    if (s_out_frame) run_cur++;
    else begin
      if (run_cur != 0) last_run = run_cur;
      run_cur = 0;
    end
  end

  always begin
    @(posedge clk);
    #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [FLIT_W-1:0] f, input int max_wait, input bit expect_deliv, output bit hs);
    p_in_flit  = f;
    p_in_valid = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (p_in_ready) begin
        hs = 1'b1;
        if (expect_deliv) exp_q.push_back(f);
        break;
      end
    end
    tick();
  endtask

  task automatic send_ok(input logic [FLIT_W-1:0] f);
    bit hs;
    send(f, 200, 1'b1, hs);
    chk(hs, "send_handshake", 64'(hs), 64'h1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    repeat (2) tick();
    chk(exp_q.size() == 0, name, 64'(exp_q.size()), 64'h0);
  endtask

  task automatic check_zero_outs(input string name);
    logic [62:0] v;
    logic [58:0] v1;
    @(negedge clk);
    v  = {p_in_ready, s_out_data, s_out_frame, s_in_ready, p_out_flit, p_out_valid, err_pulse, err_cnt};
    v1 = {p1_in_ready, s1_data, s1_frame, s1_rdy, p1_out_flit, p1_out_valid, err1_pulse, err1_cnt};
    chk(v == '0, name, 64'(v), 64'h0);
    chk(v1 == '0, {name, "_lane1"}, 64'(v1), 64'h0);
  endtask

  task automatic check_errors(input string name);
    chk(int'(err_cnt) == exp_err, {name, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
    chk(pulses_seen == exp_pulses, {name, "_pulses"}, 64'(pulses_seen), 64'(exp_pulses));
  endtask

  initial begin
    bit hs;
    int frames, lat, n_acc;
    logic [FLIT_W-1:0] got, f;
    p_in_flit = '0; p_in_valid = 1'b0; inj_mask = '0; drop_frame = 1'b0;
    rdy_manual = 1'b1; rand_rdy_mode = 1'b0;
    p1_in_flit = '0; p1_in_valid = 1'b0; p1_out_ready = 1'b1;

    rst = 1'b1;
    repeat (3) tick();
    check_zero_outs("reset_state");
    tick();
    rst = 1'b0;
    check_zero_outs("post_reset_cycle");

    // 1-bit lane: frame length and loopback latency
    p1_in_flit  = 34'h2_DEAD_BEEF;
    p1_in_valid = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (p1_in_ready) begin hs = 1'b1; break; end
    end
    chk(hs, "lane1_handshake", 64'(hs), 64'h1);
    frames = 0; lat = 0; got = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) p1_in_valid = 1'b0;
      if (s1_frame) frames++;
      if (p1_out_valid && lat == 0) begin lat = k; got = p1_out_flit; end
    end
    chk(frames == NB1, "lane1_frame_cycles", 64'(frames), 64'(NB1));
    chk(lat == NB1 + 1, "lane1_latency", 64'(lat), 64'(NB1 + 1));
    chk(got == 34'h2_DEAD_BEEF, "lane1_flit", 64'(got), 64'h2_DEAD_BEEF);
    chk(err1_cnt == '0, "lane1_err_cnt", 64'(err1_cnt), 64'h0);
    tick();

    // Back-to-back burst on the 8-bit lane
    send_ok(34'd1);
    send_ok(34'd2);
    send_ok(34'd3);
    p_in_valid = 1'b0;
    wait_drain("burst_drain");
    chk(last_run == 3 * NB, "burst_frame_run", 64'(last_run), 64'(3 * NB));

    // Single-bit corruption of frame bit 5 (beat 0)
    send(34'h1_2345_6789, 200, 1'b0, hs);
    chk(hs, "parity_handshake", 64'(hs), 64'h1);
    p_in_valid = 1'b0;
    inj_mask = 8'h20;
    tick();
    inj_mask = '0;
    exp_err++; exp_pulses++;
    send_ok(34'h0_CAFE_F00D);
    p_in_valid = 1'b0;
    wait_drain("parity_drain");
    check_errors("parity");

    // Frame cut after 3 of NB beats
    send(34'h3_0000_AAAA, 200, 1'b0, hs);
    chk(hs, "frame_cut_handshake", 64'(hs), 64'h1);
    p_in_valid = 1'b0;
    repeat (3) tick();
    drop_frame = 1'b1;
    repeat (2) tick();
    drop_frame = 1'b0;
    exp_err++; exp_pulses++;
    send_ok(34'h1_5555_0001);
    p_in_valid = 1'b0;
    wait_drain("frame_cut_drain");
    check_errors("frame_cut");

    // Credit backpressure: consumer stalled, sender keeps offering
    rdy_manual = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      f = {2'($urandom_range(0, 3)), 32'($urandom)};
      send(f, 60, 1'b1, hs);
      if (!hs) break;
      n_acc++;
    end
    p_in_valid = 1'b0;
    @(negedge clk);
    chk(n_acc >= DEPTH - 1 && n_acc <= DEPTH, "credit_buffered", 64'(n_acc), 64'(DEPTH));
    chk(s_in_ready == 1'b0, "credit_ready_low", 64'(s_in_ready), 64'h0);
    chk(p_out_valid == 1'b1, "credit_head_valid", 64'(p_out_valid), 64'h1);
    rdy_manual = 1'b1;
    wait_drain("credit_drain");
    check_errors("credit");

    // Random traffic, random consumer stalls, occasional corrupted frames
    rand_rdy_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      p_in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      f = {2'($urandom_range(0, 3)), 32'($urandom)};
      if ($urandom_range(0, 7) == 0) begin
        send(f, 200, 1'b0, hs);
        chk(hs, "rand_bad_handshake", 64'(hs), 64'h1);
        p_in_valid = 1'b0;
        inj_mask = 8'(1 << $urandom_range(0, LANE_W - 1));
        tick();
        inj_mask = '0;
        exp_err++; exp_pulses++;
      end else begin
        send_ok(f);
      end
    end
    p_in_valid = 1'b0;
    rand_rdy_mode = 1'b0;
    wait_drain("random_drain");
    check_errors("random");

    // Reset in the middle of a frame
    send(34'h2_1111_2222, 200, 1'b0, hs);
    chk(hs, "rst_mid_handshake", 64'(hs), 64'h1);
    p_in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_zero_outs("rst_mid_frame");
    tick();
    rst = 1'b0;
    check_zero_outs("rst_mid_after");
    exp_q.delete();
    exp_err = 0;
    tick();
    send_ok(34'h0_0BAD_F00D);
    send_ok(34'h3_FFFF_FFFF);
    p_in_valid = 1'b0;
    wait_drain("post_rst_drain");
    check_errors("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
